// File: rtl/pim_dma_burst_if.sv
// Shared-bus master port of the PIM burst DMA: request/grant handshake plus
// the single-beat read/write access signals.
`timescale 1ns/1ps

interface pim_dma_burst_if;
   logic        bus_req;
   logic        bus_gnt;
   logic [31:0] dma_addr;
   logic        dma_write;
   logic        dma_read;
   logic [3:0]  dma_size;
   logic [31:0] dma_wr_data;
   logic [31:0] dma_rd_data;

   modport master (
      output bus_req, dma_addr, dma_write, dma_read, dma_size, dma_wr_data,
      input  bus_gnt, dma_rd_data
   );

   modport slave (
      input  bus_req, dma_addr, dma_write, dma_read, dma_size, dma_wr_data,
      output bus_gnt, dma_rd_data
   );
endinterface

// File: rtl/pim_dma_burst.sv
// Burst DMA between system memory and the PIM macro: polls PIM status before
// every burst, reads up to BURST words into a buffer, then writes them out.
`timescale 1ns/1ps

module pim_dma_burst #(
   parameter logic [31:0] PIM_CTRL         = 32'h2000_0010,
   parameter logic [31:0] PIM_R            = 32'h2000_0020,
   parameter logic [31:0] PIM_W_WEIGHT     = 32'h2000_0040,
   parameter logic [31:0] PIM_W_ACTIVATION = 32'h2000_0080,
   parameter int          SIZE_W           = 13,
   parameter int          BURST            = 4,
   parameter int          POLL_LIMIT       = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_dma_en,
   input  logic [2:0]        i_funct3,
   input  logic [3:0]        i_sel_pim,
   input  logic [SIZE_W-1:0] i_size,
   input  logic [31:0]       i_mem_addr,
   input  logic [7:0]        i_stride,
   pim_dma_burst_if.master   bus,
   output logic              o_dma_busy,
   output logic              o_dma_done,
   output logic              o_dma_err
);

   localparam int CW = $clog2(BURST) + 1;
   localparam int AW = $clog2(BURST);
   localparam int PW = $clog2(POLL_LIMIT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_POLL, S_PCHK, S_RD, S_RDRAIN, S_WR, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [3:0]        sel_q, sel_d;
   logic [SIZE_W-1:0] remaining_q, remaining_d;
   logic [31:0]       addr_q, addr_d;
   logic [7:0]        stride_q, stride_d;
   logic              err_q, err_d;
   logic [PW-1:0]     pollCnt_q, pollCnt_d;
   logic [CW-1:0]     chunk_q, chunk_d;
   logic [CW-1:0]     rdCnt_q, rdCnt_d;
   logic [CW-1:0]     capPtr_q, capPtr_d;
   logic              capPend_q, capPend_d;
   logic [CW-1:0]     wrIdx_q, wrIdx_d;
   logic [31:0]       buf_q [BURST];

   logic              isLoad;
   logic              pimReady;
   logic [31:0]       rdAddr;
   logic [31:0]       wrAddr;
   logic [31:0]       strideExt;
   logic [CW-1:0]     chunkNext;

   always_comb begin
      isLoad    = (funct3_q == 3'b100);
      strideExt = {24'd0, stride_q};
      rdAddr    = isLoad ? PIM_R : addr_q;
      case (funct3_q)
         3'b001:  wrAddr = PIM_W_WEIGHT | {28'd0, sel_q};
         3'b010:  wrAddr = PIM_W_ACTIVATION | {28'd0, sel_q};
         default: wrAddr = addr_q;
      endcase
      pimReady  = isLoad ? (!bus.dma_rd_data[0] && bus.dma_rd_data[1]) : !bus.dma_rd_data[0];
      chunkNext = (remaining_q >= SIZE_W'(BURST)) ? CW'(BURST) : remaining_q[CW-1:0];
   end

   // Next-state logic; a read accepted this cycle is captured on the next one,
   // so the capture pointer follows capPend_q independently of the grant.
   always_comb begin
      state_d         = state_q;
      funct3_d        = funct3_q;
      sel_d           = sel_q;
      remaining_d     = remaining_q;
      addr_d          = addr_q;
      stride_d        = stride_q;
      err_d           = err_q;
      pollCnt_d       = pollCnt_q;
      chunk_d         = chunk_q;
      rdCnt_d         = rdCnt_q;
      wrIdx_d         = wrIdx_q;
      capPend_d       = 1'b0;
      capPtr_d        = capPend_q ? capPtr_q + CW'(1) : capPtr_q;
      bus.bus_req     = 1'b0;
      bus.dma_addr    = 32'd0;
      bus.dma_write   = 1'b0;
      bus.dma_read    = 1'b0;
      bus.dma_size    = 4'd0;
      bus.dma_wr_data = 32'd0;
      o_dma_busy      = 1'b0;
      o_dma_done      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_dma_en) begin
               funct3_d    = i_funct3;
               sel_d       = i_sel_pim;
               remaining_d = i_size;
               addr_d      = i_mem_addr;
               stride_d    = i_stride;
               err_d       = 1'b0;
               pollCnt_d   = '0;
               if (!(i_funct3 == 3'b001 || i_funct3 == 3'b010 || i_funct3 == 3'b100)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else if (i_size == '0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_POLL;
               end
            end
         end
         S_POLL: begin
            o_dma_busy  = 1'b1;
            bus.bus_req = 1'b1;
            if (bus.bus_gnt) begin
               bus.dma_read = 1'b1;
               bus.dma_addr = PIM_CTRL;
               bus.dma_size = 4'b1111;
               state_d      = S_PCHK;
            end
         end
         S_PCHK: begin
            o_dma_busy = 1'b1;
            if (pimReady) begin
               chunk_d   = chunkNext;
               pollCnt_d = '0;
               rdCnt_d   = '0;
               capPtr_d  = '0;
               wrIdx_d   = '0;
               state_d   = S_RD;
            end else begin
               pollCnt_d = pollCnt_q + PW'(1);
               if (pollCnt_q == PW'(POLL_LIMIT - 1)) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_POLL;
               end
            end
         end
         S_RD: begin
            o_dma_busy  = 1'b1;
            bus.bus_req = 1'b1;
            if (bus.bus_gnt) begin
               bus.dma_read = 1'b1;
               bus.dma_addr = rdAddr;
               bus.dma_size = 4'b1111;
               capPend_d    = 1'b1;
               rdCnt_d      = rdCnt_q + CW'(1);
               if (!isLoad) begin
                  addr_d = addr_q + strideExt;
               end
               if (rdCnt_q + CW'(1) == chunk_q) begin
                  state_d = S_RDRAIN;
               end
            end
         end
         S_RDRAIN: begin
            o_dma_busy = 1'b1;
            state_d    = S_WR;
         end
         S_WR: begin
            o_dma_busy  = 1'b1;
            bus.bus_req = 1'b1;
            if (bus.bus_gnt) begin
               bus.dma_write   = 1'b1;
               bus.dma_addr    = wrAddr;
               bus.dma_size    = 4'b1111;
               bus.dma_wr_data = buf_q[wrIdx_q[AW-1:0]];
               wrIdx_d         = wrIdx_q + CW'(1);
               remaining_d     = remaining_q - SIZE_W'(1);
               if (isLoad) begin
                  addr_d = addr_q + strideExt;
               end
               if (wrIdx_q + CW'(1) == chunk_q) begin
                  state_d = (remaining_q == SIZE_W'(1)) ? S_DONE : S_POLL;
               end
            end
         end
         S_DONE: begin
            o_dma_done = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         funct3_q    <= 3'd0;
         sel_q       <= 4'd0;
         remaining_q <= '0;
         addr_q      <= 32'd0;
         stride_q    <= 8'd0;
         err_q       <= 1'b0;
         pollCnt_q   <= '0;
         chunk_q     <= '0;
         rdCnt_q     <= '0;
         capPtr_q    <= '0;
         capPend_q   <= 1'b0;
         wrIdx_q     <= '0;
      end else begin
         state_q     <= state_d;
         funct3_q    <= funct3_d;
         sel_q       <= sel_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         stride_q    <= stride_d;
         err_q       <= err_d;
         pollCnt_q   <= pollCnt_d;
         chunk_q     <= chunk_d;
         rdCnt_q     <= rdCnt_d;
         capPtr_q    <= capPtr_d;
         capPend_q   <= capPend_d;
         wrIdx_q     <= wrIdx_d;
      end
   end

   // Buffer contents are don't-care after reset, so no reset branch here.
   always_ff @(posedge i_clk) begin
      for (int i = 0; i < BURST; i++) begin
         if (capPend_q && capPtr_q == CW'(i)) begin
            buf_q[i] <= bus.dma_rd_data;
         end
      end
   end

   assign o_dma_err = err_q;

endmodule

// File: tb/tb_pim_dma_burst.sv
// Self-checking bench for pim_dma_burst: bus slave model with PIM status
// behaviour, expected-access scoreboard and an independent bus monitor.
`timescale 1ns/1ps

module tb_pim_dma_burst;

   localparam logic [31:0] CTRL = 32'h2000_0010;
   localparam logic [31:0] PIMR = 32'h2000_0020;
   localparam logic [31:0] WWT  = 32'h2000_0040;
   localparam logic [31:0] WACT = 32'h2000_0080;
   localparam logic [1:0]  K_RD   = 2'd0;
   localparam logic [1:0]  K_WR   = 2'd1;
   localparam logic [1:0]  K_DONE = 2'd2;

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [2:0]  funct3;
   logic [3:0]  sel;
   logic [12:0] size;
   logic [31:0] memAddr;
   logic [7:0]  stride;
   logic        busy, done, err;

   int   checks = 0;
   int   failures = 0;
   exp_t expQ[$];

   int          busyLeft = 0;
   bit          busyForever = 1'b0;
   int          pimCount = 0;
   bit          stallMode = 1'b0;
   int          rdSeen = 0;
   int          wrSeen = 0;
   int          dropLeft = 0;
   int          cyc = 0;
   int          lastAccCyc = 0;
   logic [31:0] rdv;

   always #5 clk = ~clk;

   pim_dma_burst_if bus ();

   pim_dma_burst #(.BURST(4), .POLL_LIMIT(4)) dut (
      .i_clk(clk), .i_rst(rst), .i_dma_en(en), .i_funct3(funct3),
      .i_sel_pim(sel), .i_size(size), .i_mem_addr(memAddr), .i_stride(stride),
      .bus(bus), .o_dma_busy(busy), .o_dma_done(done), .o_dma_err(err)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return 32'hA500_0000 ^ a;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   task automatic pushEv(input logic [1:0] k, input logic [31:0] a, input logic [31:0] d,
                         input logic e, input int lat);
      exp_t x;
      x.kind = k; x.addr = a; x.data = d; x.err = e; x.lat = lat;
      expQ.push_back(x);
   endtask

   // Expected traffic of a memory-to-PIM run: poll, burst reads, burst writes.
   task automatic expectWriteRun(input logic [31:0] base, input logic [31:0] tgt,
                                 input int words, input int strideV);
      int          rem;
      logic [31:0] a;
      rem = words;
      a   = base;
      while (rem > 0) begin
         int chunk;
         chunk = (rem > 4) ? 4 : rem;
         pushEv(K_RD, CTRL, 32'd0, 1'b0, 0);
         for (int i = 0; i < chunk; i++) pushEv(K_RD, a + 32'(i * strideV), 32'd0, 1'b0, 0);
         for (int i = 0; i < chunk; i++) pushEv(K_WR, tgt, memWord(a + 32'(i * strideV)), 1'b0, 0);
         a   = a + 32'(chunk * strideV);
         rem = rem - chunk;
      end
      pushEv(K_DONE, 32'd0, 32'd0, 1'b0, 1);
   endtask

   task automatic applyStimulus(input logic [2:0] f3, input logic [3:0] s, input logic [12:0] n,
                                input logic [31:0] a, input logic [7:0] st);
      @(negedge clk);
      rdSeen = 0; wrSeen = 0;
      funct3 = f3; sel = s; size = n; memAddr = a; stride = st;
      en = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((expQ.size() != 0 || busy) && n < 500) begin
         @(posedge clk);
         n++;
      end
      checkOutput("drainedIdle", {32'(expQ.size()), 31'd0, busy}, 64'd0);
      repeat (2) @(posedge clk);
   endtask

   // Slave: status register, PIM result port and memory; data valid one cycle after accept.
   always @(posedge clk) begin
      if (bus.dma_read && bus.bus_gnt) begin
         if (bus.dma_addr == CTRL) begin
            if (busyForever) rdv = 32'd1;
            else if (busyLeft > 0) begin busyLeft--; rdv = 32'd1; end
            else rdv = 32'd2;
         end else if (bus.dma_addr == PIMR) begin
            rdv = 32'hBEEF_0000 + 32'(pimCount);
            pimCount++;
         end else begin
            rdv = memWord(bus.dma_addr);
         end
         bus.dma_rd_data <= rdv;
      end else begin
         bus.dma_rd_data <= 32'hDEAD_BEEF;
      end
   end

   // Monitor: pops the scoreboard on every access or done pulse, and owns the grant.
   initial begin
      exp_t e;
      bit   isDataRd;
      bus.bus_gnt = 1'b1;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            if (bus.dma_read || bus.dma_write) begin
               isDataRd   = bus.dma_read && (bus.dma_addr != CTRL);
               lastAccCyc = cyc;
               if (isDataRd) rdSeen++;
               if (bus.dma_write) wrSeen++;
               if (expQ.size() == 0) begin
                  checks++; failures++;
                  $display("[TB] FAIL unexpectedAccess actual addr=%0h expected none", bus.dma_addr);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("accessAddr", {26'd0, (bus.dma_write ? K_WR : K_RD), bus.dma_size, bus.dma_addr},
                              {26'd0, e.kind, 4'hF, e.addr});
                  if (e.kind == K_WR) checkOutput("accessData", bus.dma_wr_data, e.data);
               end
               if (stallMode && ((isDataRd && rdSeen == 2) || (bus.dma_write && wrSeen == 2))) dropLeft = 2;
            end else if (!bus.bus_gnt) begin
               checkOutput("stallGapCtl", {bus.bus_req, bus.dma_read, bus.dma_write, bus.dma_size}, {1'b1, 6'd0});
               checkOutput("stallGapData", {bus.dma_addr, bus.dma_wr_data}, 64'd0);
            end
            if (done) begin
               if (expQ.size() == 0) begin
                  checks++; failures++;
                  $display("[TB] FAIL unexpectedDone actual err=%0b expected none", err);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("doneEvent", {K_DONE, err}, {e.kind, e.err});
                  if (e.lat != 0) checkOutput("doneLatency", 64'(cyc - lastAccCyc), 64'(e.lat));
               end
            end
            if (dropLeft > 0) begin
               bus.bus_gnt = 1'b0;
               dropLeft--;
            end else begin
               bus.bus_gnt = 1'b1;
            end
         end else begin
            bus.bus_gnt = 1'b1;
         end
      end
   end

   initial begin
      int n;
      rst = 1'b1; en = 1'b0; funct3 = 3'd0; sel = 4'd0; size = 13'd0; memAddr = 32'd0; stride = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("resetCtl", {bus.bus_req, bus.dma_read, bus.dma_write, bus.dma_size, busy, done, err}, 64'd0);
      checkOutput("resetAddrData", {bus.dma_addr, bus.dma_wr_data}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // pim_write, 6 words, two bursts
      expectWriteRun(32'h100, WWT | 32'd3, 6, 4);
      applyStimulus(3'b001, 4'd3, 13'd6, 32'h100, 8'd4);
      checkOutput("firstPoll", {busy, bus.dma_read, bus.dma_addr}, {1'b1, 1'b1, CTRL});
      waitIdle();

      // pim_load with three busy polls, stride 0
      busyLeft = 3; pimCount = 0;
      for (int i = 0; i < 6; i++) pushEv(K_RD, (i < 4) ? CTRL : PIMR, 32'd0, 1'b0, 0);
      pushEv(K_WR, 32'h400, 32'hBEEF_0000, 1'b0, 0);
      pushEv(K_WR, 32'h400, 32'hBEEF_0001, 1'b0, 0);
      pushEv(K_DONE, 32'd0, 32'd0, 1'b0, 1);
      applyStimulus(3'b100, 4'd0, 13'd2, 32'h400, 8'd0);
      waitIdle();

      // PIM busy forever: poll limit reached
      busyForever = 1'b1;
      for (int i = 0; i < 4; i++) pushEv(K_RD, CTRL, 32'd0, 1'b0, 0);
      pushEv(K_DONE, 32'd0, 32'd0, 1'b1, 2);
      applyStimulus(3'b001, 4'd0, 13'd4, 32'h200, 8'd4);
      waitIdle();
      checkOutput("errSticky", err, 1);
      busyForever = 1'b0;

      // Same as the first run with grant gaps in RD and WR
      stallMode = 1'b1;
      expectWriteRun(32'h100, WWT | 32'd3, 6, 4);
      applyStimulus(3'b001, 4'd3, 13'd6, 32'h100, 8'd4);
      waitIdle();
      stallMode = 1'b0;

      // size 0
      pushEv(K_DONE, 32'd0, 32'd0, 1'b0, 0);
      applyStimulus(3'b001, 4'd0, 13'd0, 32'h100, 8'd4);
      checkOutput("size0Done", {done, err, bus.bus_req, busy}, {1'b1, 3'b000});
      @(posedge clk);
      #1;
      checkOutput("donePulseOnce", done, 0);
      waitIdle();

      // invalid funct3
      pushEv(K_DONE, 32'd0, 32'd0, 1'b1, 0);
      applyStimulus(3'b011, 4'd0, 13'd3, 32'h100, 8'd4);
      checkOutput("badFunctDone", {done, err, bus.bus_req}, {1'b1, 1'b1, 1'b0});
      waitIdle();

      // activation write with a start pulse while busy (ignored)
      expectWriteRun(32'h300, WACT | 32'd5, 1, 4);
      applyStimulus(3'b010, 4'd5, 13'd1, 32'h300, 8'd4);
      checkOutput("errClearedOnStart", err, 0);
      @(negedge clk);
      funct3 = 3'b011; size = 13'd0; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      waitIdle();

      // reset in the middle of the write phase
      expectWriteRun(32'h500, WWT | 32'd1, 4, 8);
      applyStimulus(3'b001, 4'd1, 13'd4, 32'h500, 8'd8);
      n = 0;
      while (wrSeen < 2 && n < 200) begin
         @(posedge clk);
         n++;
      end
      checkOutput("reachedWrPhase", 64'(wrSeen >= 2), 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("midResetCtl", {bus.bus_req, bus.dma_read, bus.dma_write, bus.dma_size, busy, done, err}, 64'd0);
      checkOutput("midResetAddrData", {bus.dma_addr, bus.dma_wr_data}, 64'd0);
      expQ.delete();
      @(negedge clk);
      rst = 1'b0;
      expectWriteRun(32'h600, WWT | 32'd1, 1, 4);
      applyStimulus(3'b001, 4'd1, 13'd1, 32'h600, 8'd4);
      waitIdle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
